// File: rtl/ysyx_22041211_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU.
// One transaction in flight; a watchdog answers lost responses with an error.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_i,
    input  logic [ADDR_LEN-1:0] ifu_addr_i,
    output logic                ifu_gnt_o,
    output logic                ifu_rvalid_o,
    output logic [DATA_LEN-1:0] ifu_rdata_o,
    output logic                ifu_err_o,

    input  logic                lsu_req_i,
    input  logic                lsu_wen_i,
    input  logic [ADDR_LEN-1:0] lsu_addr_i,
    input  logic [DATA_LEN-1:0] lsu_wdata_i,
    input  logic [3:0]          lsu_wmask_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_LEN-1:0] lsu_rdata_o,
    output logic                lsu_err_o,

    output logic                mem_req_o,
    output logic                mem_wen_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [3:0]          mem_wmask_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i
);

    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t              state;
    owner_t              owner;
    owner_t              last_owner;
    logic                cmd_wen;
    logic [ADDR_LEN-1:0] cmd_addr;
    logic [DATA_LEN-1:0] cmd_wdata;
    logic [3:0]          cmd_wmask;
    logic [WDOG_W-1:0]   wdog;

    logic idle;
    logic pick_ifu;
    logic pick_lsu;
    logic accepted;
    logic resp_ok;
    logic resp_err;
    logic resp;
    logic to_ifu;
    logic to_lsu;

    assign idle = (state == S_IDLE);

    // On a tie the requester that did not own the previous transaction wins.
    assign pick_ifu = ifu_req_i && (!lsu_req_i || last_owner == OWN_LSU);
    assign pick_lsu = lsu_req_i && (!ifu_req_i || last_owner == OWN_IFU);

    assign ifu_gnt_o = rst && idle && pick_ifu;
    assign lsu_gnt_o = rst && idle && pick_lsu;

    assign accepted = (state == S_ISSUE) && mem_ready_i;
    assign resp_ok  = (accepted || state == S_WAIT) && mem_rvalid_i;
    assign resp_err = (state == S_WAIT) && !mem_rvalid_i
                    && (wdog == WDOG_LAST);
    assign resp     = resp_ok || resp_err;

    assign to_ifu = (owner == OWN_IFU);
    assign to_lsu = (owner == OWN_LSU);

    assign ifu_rvalid_o = resp && to_ifu;
    assign ifu_err_o    = resp_err && to_ifu;
    assign ifu_rdata_o  = (resp_ok && to_ifu) ? mem_rdata_i : '0;

    assign lsu_rvalid_o = resp && to_lsu;
    assign lsu_err_o    = resp_err && to_lsu;
    assign lsu_rdata_o  = (resp_ok && to_lsu) ? mem_rdata_i : '0;

    assign mem_req_o   = (state == S_ISSUE);
    assign mem_wen_o   = cmd_wen;
    assign mem_addr_o  = cmd_addr;
    assign mem_wdata_o = cmd_wdata;
    assign mem_wmask_o = cmd_wmask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            last_owner <= OWN_LSU;
            cmd_wen    <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wmask  <= 4'b0000;
            wdog       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    unique case (1'b1)
                        pick_ifu: begin
                            owner      <= OWN_IFU;
                            last_owner <= OWN_IFU;
                            cmd_wen    <= 1'b0;
                            cmd_addr   <= ifu_addr_i;
                            cmd_wdata  <= '0;
                            cmd_wmask  <= 4'b1111;
                            state      <= S_ISSUE;
                        end
                        pick_lsu: begin
                            owner      <= OWN_LSU;
                            last_owner <= OWN_LSU;
                            cmd_wen    <= lsu_wen_i;
                            cmd_addr   <= lsu_addr_i;
                            cmd_wdata  <= lsu_wdata_i;
                            cmd_wmask  <= lsu_wmask_i;
                            state      <= S_ISSUE;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    if (mem_ready_i) begin
                        // zero-latency memories answer in the accept cycle
                        state <= mem_rvalid_i ? S_IDLE : S_WAIT;
                        wdog  <= '0;
                    end
                end
                S_WAIT: begin
                    if (resp) begin
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_ysyx_22041211_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    ysyx_22041211_mem_arbiter #(
        .ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
        .ifu_gnt_o(ifu_gnt), .ifu_rvalid_o(ifu_rvalid),
        .ifu_rdata_o(ifu_rdata), .ifu_err_o(ifu_err),
        .lsu_req_i(lsu_req), .lsu_wen_i(lsu_wen),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_wmask_i(lsu_wmask),
        .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .mem_req_o(mem_req), .mem_wen_o(mem_wen),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    // {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err, mem_req}
    function automatic logic [6:0] flags();
        return {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid,
                ifu_err, lsu_err, mem_req};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req = 1'b0; ifu_addr = '0;
        lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0;
        lsu_wdata = '0; lsu_wmask = 4'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic [6:0]  f;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic lreq,
                                input logic rdy, input logic rv,
                                input logic [31:0] rd,
                                input logic [6:0] f,
                                input logic [31:0] erd);
        vec_t v;
        v.ireq = ireq; v.lreq = lreq; v.rdy = rdy; v.rv = rv;
        v.rd = rd; v.f = f; v.erd = erd;
        return v;
    endfunction

    vec_t vt[19];

    // transaction-level reference state for the random phase
    bit          m_busy, m_acc, m_own, m_last, m_wen;
    int          m_waited;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;

    initial begin
        int grants[4];
        int ng;
        bit p_ig, p_lg;
        bit e_ig, e_lg, e_mreq, ok, er;

        clear_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset_flags", 64'(flags()), 64'(7'b0));
        chk("reset_cmd", 64'({mem_wen, mem_addr, mem_wmask}), 64'(0));
        chk("reset_wdata", 64'(mem_wdata), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_hold", 64'({flags(), ifu_rdata, lsu_rdata}), 64'(0));

        // ---- table: IFU fetch, zero-latency load, stray rvalids, ties
        vt[0]  = mk(1, 0, 0, 0, 32'h0,        7'b1000000, 0);
        vt[1]  = mk(0, 0, 1, 0, 32'h0,        7'b0000001, 0);
        vt[2]  = mk(0, 0, 0, 0, 32'h0,        7'b0000000, 0);
        vt[3]  = mk(0, 0, 0, 1, 32'h00100073, 7'b0010000, 32'h00100073);
        vt[4]  = mk(0, 0, 0, 0, 32'h0,        7'b0000000, 0);
        vt[5]  = mk(0, 1, 0, 0, 32'h0,        7'b0100000, 0);
        vt[6]  = mk(0, 0, 1, 1, 32'h12345678, 7'b0001001, 32'h12345678);
        vt[7]  = mk(0, 1, 0, 0, 32'h0,        7'b0100000, 0);
        vt[8]  = mk(0, 0, 1, 0, 32'h0,        7'b0000001, 0);
        vt[9]  = mk(0, 0, 0, 1, 32'hCAFEF00D, 7'b0001000, 32'hCAFEF00D);
        vt[10] = mk(0, 0, 0, 0, 32'h0,        7'b0000000, 0);
        vt[11] = mk(0, 0, 0, 1, 32'h00001111, 7'b0000000, 0);
        vt[12] = mk(1, 1, 0, 0, 32'h0,        7'b1000000, 0);
        vt[13] = mk(0, 1, 0, 1, 32'h00002222, 7'b0000001, 0);
        vt[14] = mk(0, 1, 1, 0, 32'h0,        7'b0000001, 0);
        vt[15] = mk(0, 1, 0, 1, 32'hAAAA5555, 7'b0010000, 32'hAAAA5555);
        vt[16] = mk(0, 1, 0, 0, 32'h0,        7'b0100000, 0);
        vt[17] = mk(0, 0, 1, 1, 32'h0BADF00D, 7'b0001001, 32'h0BADF00D);
        vt[18] = mk(0, 0, 0, 0, 32'h0,        7'b0000000, 0);

        ifu_addr = 32'h80000000;
        lsu_addr = 32'h80000100;
        lsu_wmask = 4'hF;
        for (int i = 0; i < 19; i++) begin
            tick();
            ifu_req = vt[i].ireq; lsu_req = vt[i].lreq;
            mem_ready = vt[i].rdy; mem_rvalid = vt[i].rv;
            mem_rdata = vt[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vt[i].f));
            if (vt[i].f[4])
                chk($sformatf("vec%0d_ifu_rdata", i), 64'(ifu_rdata),
                    64'(vt[i].erd));
            if (vt[i].f[3])
                chk($sformatf("vec%0d_lsu_rdata", i), 64'(lsu_rdata),
                    64'(vt[i].erd));
            if (vt[i].f[0] && i == 1)
                chk("vec1_fetch_cmd", 64'({mem_wen, mem_addr, mem_wmask}),
                    64'({1'b0, 32'h80000000, 4'hF}));
        end

        // ---- round robin with both requesters always asking
        do_reset();
        tick();
        ifu_req = 1; lsu_req = 1; mem_ready = 1; mem_rvalid = 1;
        for (int k = 0; k < 4; k++) grants[k] = 2;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (ifu_gnt && lsu_gnt)
                chk("rr_single_gnt", 64'(2'b11), 64'(2'b01));
            if (ifu_gnt) begin grants[ng] = 0; ng++; end
            else if (lsu_gnt) begin grants[ng] = 1; ng++; end
            tick();
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_order%0d", k), 64'(grants[k]), 64'(k % 2));

        // ---- store with memory stalling the command for 5 cycles
        do_reset();
        tick();
        lsu_req = 1; lsu_wen = 1; lsu_addr = 32'h80000010;
        lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'b0011;
        @(negedge clk);
        chk("st_gnt", 64'(flags()), 64'(7'b0100000));
        tick();
        lsu_req = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0;
        lsu_wmask = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("st_hold%0d", c),
                64'({mem_req, mem_wen, mem_addr, mem_wmask}),
                64'({1'b1, 1'b1, 32'h80000010, 4'b0011}));
            chk($sformatf("st_wdata%0d", c), 64'(mem_wdata),
                64'(32'hDEADBEEF));
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("st_accept", 64'(flags()), 64'(7'b0000001));
        tick();
        mem_ready = 0; mem_rvalid = 1;
        @(negedge clk);
        chk("st_resp", 64'(flags()), 64'(7'b0001000));
        tick();
        mem_rvalid = 0;

        // ---- watchdog timeout, then a late response
        do_reset();
        tick();
        ifu_req = 1; ifu_addr = 32'h80000040;
        @(negedge clk);
        chk("to_gnt", 64'(flags()), 64'(7'b1000000));
        tick();
        ifu_req = 0; mem_ready = 1;
        @(negedge clk);
        tick();
        mem_ready = 0; mem_rdata = 32'h55AA55AA;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            if (c < TO)
                chk($sformatf("to_wait%0d", c), 64'(flags()), 64'(0));
            else
                chk("to_err", 64'({flags(), ifu_rdata}),
                    64'({7'b0010100, 32'h0}));
            tick();
        end
        mem_rvalid = 1;
        @(negedge clk);
        chk("to_late_rvalid", 64'(flags()), 64'(0));
        tick();
        mem_rvalid = 0; ifu_req = 1;
        @(negedge clk);
        chk("to2_gnt", 64'(flags()), 64'(7'b1000000));
        tick();
        ifu_req = 0; mem_ready = 1;
        @(negedge clk);
        tick();
        mem_ready = 0;
        for (int c = 1; c <= TO; c++) begin
            mem_rvalid = (c == TO);
            mem_rdata = 32'h13579BDF;
            @(negedge clk);
            if (c == TO)
                chk("to_rvalid_wins", 64'({flags(), ifu_rdata}),
                    64'({7'b0010000, 32'h13579BDF}));
            tick();
        end
        mem_rvalid = 0;

        // ---- reset during WAIT abandons the transaction
        do_reset();
        tick();
        lsu_req = 1; lsu_addr = 32'h80000200; lsu_wmask = 4'hF;
        @(negedge clk);
        tick();
        lsu_req = 0; mem_ready = 1;
        @(negedge clk);
        tick();
        mem_ready = 0;
        @(negedge clk);
        chk("rst_in_wait", 64'(flags()), 64'(0));
        tick();
        ifu_req = 1; lsu_req = 1;
        #1 rst = 1'b0;
        #1;
        chk("rst_outputs", 64'({flags(), lsu_rdata}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        ifu_req = 0; lsu_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("rst_stale_rvalid", 64'({flags(), lsu_rdata}), 64'(0));
        tick();
        mem_rvalid = 0; ifu_req = 1; lsu_req = 1;
        @(negedge clk);
        chk("rst_tie_ifu", 64'(flags()), 64'(7'b1000000));
        tick();

        // ---- randomized traffic vs reference model
        do_reset();
        m_busy = 0; m_acc = 0; m_own = 0; m_last = 1; m_waited = 0;
        m_wen = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
        p_ig = 0; p_lg = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!ifu_req || p_ig) begin
                ifu_req = ($urandom_range(0, 9) < 6);
                ifu_addr = $urandom;
            end
            if (!lsu_req || p_lg) begin
                lsu_req = ($urandom_range(0, 9) < 6);
                lsu_wen = 1'($urandom_range(0, 1));
                lsu_addr = $urandom;
                lsu_wdata = $urandom;
                lsu_wmask = 4'($urandom);
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            @(negedge clk);

            e_ig = !m_busy && ifu_req && (!lsu_req || m_last);
            e_lg = !m_busy && lsu_req && (!ifu_req || !m_last);
            e_mreq = m_busy && !m_acc;
            ok = m_busy && (m_acc || mem_ready) && mem_rvalid;
            er = m_busy && m_acc && !mem_rvalid && (m_waited == TO - 1);

            chk($sformatf("rnd%0d_flags", cyc), 64'(flags()),
                64'({e_ig, e_lg, (ok || er) && !m_own,
                     (ok || er) && m_own, er && !m_own, er && m_own,
                     e_mreq}));
            if (e_mreq) begin
                chk($sformatf("rnd%0d_cmd", cyc),
                    64'({mem_wen, mem_addr, mem_wmask}),
                    64'({m_wen, m_addr, m_wmask}));
                if (m_wen)
                    chk($sformatf("rnd%0d_wdata", cyc), 64'(mem_wdata),
                        64'(m_wdata));
            end
            if (er || (ok && !m_wen))
                chk($sformatf("rnd%0d_rdata", cyc),
                    64'(m_own ? lsu_rdata : ifu_rdata),
                    64'(er ? 32'h0 : mem_rdata));

            if (!m_busy) begin
                if (e_ig) begin
                    m_busy = 1; m_acc = 0; m_own = 0; m_last = 0;
                    m_wen = 0; m_addr = ifu_addr; m_wmask = 4'hF;
                    m_wdata = 0;
                end else if (e_lg) begin
                    m_busy = 1; m_acc = 0; m_own = 1; m_last = 1;
                    m_wen = lsu_wen; m_addr = lsu_addr;
                    m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end
            end else if (!m_acc) begin
                if (mem_ready) begin
                    if (ok) m_busy = 0;
                    else begin m_acc = 1; m_waited = 0; end
                end
            end else begin
                if (ok || er) m_busy = 0;
                else m_waited++;
            end
            p_ig = e_ig;
            p_lg = e_lg;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
